// File: rtl/comms_link_scheduler.sv
// comms_link_scheduler
//   Shares one bit-serial comms link among NUM_REQ requesters.
//   - Round-robin grant. The scan starts one past the last finished owner.
//   - The winner's frame is captured into link_send_buf on the grant edge.
//     link_start is then pulsed for START_W cycles.
//   - link_busy is supervised with a TIMEOUT-cycle watchdog in two places:
//     waiting for busy to rise, and waiting for busy to fall.
//   - Received frames are held in a single-entry valid/ready register.
//     A frame that arrives while the register is full is dropped and
//     rx_overflow is set (sticky until reset).
// Ports
//   clk, rst                  clock, async active-high reset
//   req_valid/req_data        per-requester frame offer (data at [i*DATA_W +: DATA_W])
//   req_ready/done/err        one-hot 1-cycle pulses: accepted / sent / timed out
//   link_ready_send           link can accept a frame
//   link_busy                 link is shifting a frame
//   link_start                start pulse to link
//   link_send_buf             frame presented to link
//   link_rx_new, link_rx_buf  new received frame strobe + data
//   rx_valid/rx_data/rx_ready buffered receive output
//   rx_overflow               sticky frame-drop flag
//   busy, owner               scheduler active / current-or-last grantee

// Per-requester handshake pulse register.
module comms_link_scheduler_port (
    input  logic clk,
    input  logic rst,
    input  logic selGrant,
    input  logic selOwner,
    input  logic grantPulse,
    input  logic donePulse,
    input  logic errPulse,
    output logic ready,
    output logic done,
    output logic err
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= grantPulse && selGrant;
            done  <= donePulse && selOwner;
            err   <= errPulse && selOwner;
        end
    end
endmodule

module comms_link_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int START_W = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    input  logic                       link_ready_send,
    input  logic                       link_busy,
    output logic                       link_start,
    output logic [DATA_W-1:0]          link_send_buf,
    input  logic                       link_rx_new,
    input  logic [DATA_W-1:0]          link_rx_buf,
    output logic                       rx_valid,
    output logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_ready,
    output logic                       rx_overflow,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int ST_W  = $clog2(START_W + 1);

    typedef enum logic [2:0] {
        IDLE, GRANT, START, WAIT_BUSY, XFER, DONE, ERR
    } state_t;

    state_t            state, stateNxt;
    logic [OWN_W-1:0]  lastOwner, lastOwnerNxt;
    logic [OWN_W-1:0]  winner;
    logic [TO_W-1:0]   toCnt, toCntNxt;
    logic [ST_W-1:0]   startCnt, startCntNxt;
    logic              linkStartNxt;
    logic              grantPulse, donePulse, errPulse;

    // Requester index k positions past base, wrapping at NUM_REQ.
    function automatic logic [OWN_W-1:0] rotIdx(input logic [OWN_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return OWN_W'(s);
    endfunction

    // Round-robin pick. The scan runs from farthest to nearest so that the
    // nearest pending requester after lastOwner is written last and wins.
    always_comb begin
        winner = lastOwner;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[rotIdx(lastOwner, k)]) winner = rotIdx(lastOwner, k);
        end
    end

    always_comb begin
        stateNxt     = state;
        lastOwnerNxt = lastOwner;
        toCntNxt     = toCnt;
        startCntNxt  = startCnt;
        linkStartNxt = 1'b0;
        grantPulse   = 1'b0;
        donePulse    = 1'b0;
        errPulse     = 1'b0;
        case (state)
            IDLE: begin
                if ((|req_valid) && link_ready_send) begin
                    stateNxt   = GRANT;
                    grantPulse = 1'b1;
                end
            end
            GRANT: begin
                stateNxt     = START;
                linkStartNxt = 1'b1;
                startCntNxt  = '0;
            end
            START: begin
                if (startCnt == ST_W'(START_W - 1)) begin
                    stateNxt = WAIT_BUSY;
                    toCntNxt = '0;
                end else begin
                    startCntNxt  = startCnt + 1'b1;
                    linkStartNxt = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (link_busy) begin
                    stateNxt = XFER;
                    toCntNxt = '0;
                end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
                    stateNxt = ERR;
                    errPulse = 1'b1;
                end else begin
                    toCntNxt = toCnt + 1'b1;
                end
            end
            XFER: begin
                if (!link_busy) begin
                    stateNxt  = DONE;
                    donePulse = 1'b1;
                end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
                    stateNxt = ERR;
                    errPulse = 1'b1;
                end else begin
                    toCntNxt = toCnt + 1'b1;
                end
            end
            DONE, ERR: begin
                lastOwnerNxt = owner;
                stateNxt     = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lastOwner     <= OWN_W'(NUM_REQ - 1);
            owner         <= '0;
            toCnt         <= '0;
            startCnt      <= '0;
            link_start    <= 1'b0;
            busy          <= 1'b0;
            link_send_buf <= '0;
        end else begin
            state      <= stateNxt;
            lastOwner  <= lastOwnerNxt;
            toCnt      <= toCntNxt;
            startCnt   <= startCntNxt;
            link_start <= linkStartNxt;
            busy       <= (stateNxt != IDLE);
            // The frame is latched at grant, so a requester may drop
            // req_valid afterwards without disturbing the transfer.
            if (grantPulse) begin
                owner         <= winner;
                link_send_buf <= req_data[winner*DATA_W +: DATA_W];
            end
        end
    end

    // The ready pulse targets the winner, because owner is only updated on
    // that same edge. The done/err pulses target the settled owner.
    for (genvar i = 0; i < NUM_REQ; i++) begin : gPort
        comms_link_scheduler_port uPort (
            .clk        (clk),
            .rst        (rst),
            .selGrant   (winner == OWN_W'(i)),
            .selOwner   (owner == OWN_W'(i)),
            .grantPulse (grantPulse),
            .donePulse  (donePulse),
            .errPulse   (errPulse),
            .ready      (req_ready[i]),
            .done       (req_done[i]),
            .err        (req_err[i])
        );
    end

    // Receive buffer. A new frame may replace the held one in the same
    // cycle that the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_overflow <= 1'b0;
        end else if (link_rx_new && (!rx_valid || rx_ready)) begin
            rx_valid <= 1'b1;
            rx_data  <= link_rx_buf;
        end else if (link_rx_new) begin
            rx_overflow <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_comms_link_scheduler.sv
// Scoreboard bench for comms_link_scheduler.
// Stimulus pushes the expected handshake events; a negedge monitor pops and
// compares them whenever the DUT pulses req_ready/req_done/req_err or
// completes an rx handshake. A behavioural link model answers link_start.
module tb_comms_link_scheduler;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 256;
    localparam int START_W  = 2;
    localparam int TIMEOUT  = 64;
    localparam int EV_READY = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready, req_done, req_err;
    logic                      link_ready_send = 1'b1;
    logic                      link_busy;
    logic                      link_start;
    logic [DATA_W-1:0]         link_send_buf;
    logic                      link_rx_new = 1'b0;
    logic [DATA_W-1:0]         link_rx_buf = '0;
    logic                      rx_valid;
    logic [DATA_W-1:0]         rx_data;
    logic                      rx_ready = 1'b0;
    logic                      rx_overflow;
    logic                      busy;
    logic [1:0]                owner;

    typedef struct {
        int                  kind;
        logic [NUM_REQ-1:0]  id;
        logic [DATA_W-1:0]   data;
    } ev_t;

    ev_t               expQ[$];
    logic [DATA_W-1:0] rxQ[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, fallCyc = 0, errCyc = 0;
    int   busyMode = 0;            // 0 model, 1 stuck low, 2 stuck high
    int   busyLen = 60;
    logic busyModel = 1'b0;
    logic prevStart = 1'b0;

    assign link_busy = busyModel || (busyMode == 2);

    always #5 clk = ~clk;

    comms_link_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .START_W(START_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .link_ready_send(link_ready_send), .link_busy(link_busy),
        .link_start(link_start), .link_send_buf(link_send_buf),
        .link_rx_new(link_rx_new), .link_rx_buf(link_rx_buf),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .busy(busy), .owner(owner)
    );

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait expired (t=%0t)", name, $time);
    endtask

    function automatic logic [DATA_W-1:0] dataFor(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {8{w}};
    endfunction

    task automatic setReq(input int i, input logic [DATA_W-1:0] d);
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic pushEv(input int kind, input logic [NUM_REQ-1:0] id, input logic [DATA_W-1:0] d);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic expectFrame(input int g, input int endKind);
        pushEv(EV_READY, NUM_REQ'(1 << g), dataFor(g));
        pushEv(endKind, NUM_REQ'(1 << g), '0);
    endtask

    task automatic popEv(input int kind, input logic [NUM_REQ-1:0] id);
        ev_t e;
        if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d id %b, expected none (t=%0t)", kind, id, $time);
        end else begin
            e = expQ.pop_front();
            chk("ev_kind", DATA_W'(kind), DATA_W'(e.kind));
            chk("ev_id", DATA_W'(id), DATA_W'(e.id));
            if (kind == EV_READY) chk("ev_send_buf", link_send_buf, e.data);
        end
    endtask

    task automatic waitQ(input int n, input int maxCyc, input string name);
        int k = 0;
        while (expQ.size() > n && k < maxCyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, DATA_W'(expQ.size() <= n), DATA_W'(1));
    endtask

    task automatic waitBusy(input logic lvl, input int maxCyc, input string name);
        int k = 0;
        while (link_busy !== lvl && k < maxCyc) begin
            @(negedge clk);
            k++;
        end
        if (link_busy !== lvl) timeoutFail(name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prevStart && !link_start) fallCyc = cyc;
        prevStart = link_start;
    end

    // Monitor
    always @(negedge clk) begin
        if (req_ready != '0) popEv(EV_READY, req_ready);
        if (req_done != '0) popEv(EV_DONE, req_done);
        if (req_err != '0) begin
            errCyc = cyc;
            popEv(EV_ERR, req_err);
        end
        if (rx_valid && rx_ready) begin
            if (rxQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
                chk("rx_data", rx_data, rxQ.pop_front());
            end
        end
    end

    // Link model: busy rises 2 cycles after the start pulse ends and stays
    // high for busyLen cycles.
    initial begin
        forever begin
            @(negedge link_start);
            if (busyMode == 0) begin
                repeat (2) @(posedge clk);
                #1 busyModel = 1'b1;
                repeat (busyLen) @(posedge clk);
                #1 busyModel = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] fx, fy, fz, fw;
        fx = {8{32'h1111_AAAA}};
        fy = {8{32'h2222_BBBB}};
        fz = {8{32'h3333_CCCC}};
        fw = {8{32'h4444_DDDD}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", DATA_W'(req_ready), '0);
        chk("rst_link_start", DATA_W'(link_start), '0);
        chk("rst_send_buf", link_send_buf, '0);
        chk("rst_rx_valid", DATA_W'(rx_valid), '0);
        chk("rst_rx_ovf", DATA_W'(rx_overflow), '0);
        chk("rst_busy", DATA_W'(busy), '0);
        chk("rst_owner", DATA_W'(owner), '0);
        rst = 1'b0;

        // 1: single frame from requester 2
        setReq(2, 256'hA5);
        pushEv(EV_READY, 4'b0100, 256'hA5);
        pushEv(EV_DONE, 4'b0100, '0);
        busyLen = 60;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(posedge clk); #1;
        chk("t1_ready", DATA_W'(req_ready), DATA_W'(4'b0100));
        chk("t1_send_buf", link_send_buf, 256'hA5);
        chk("t1_start_lo0", DATA_W'(link_start), '0);
        req_valid = '0;
        @(posedge clk); #1;
        chk("t1_start_hi1", DATA_W'(link_start), DATA_W'(1));
        @(posedge clk); #1;
        chk("t1_start_hi2", DATA_W'(link_start), DATA_W'(1));
        @(posedge clk); #1;
        chk("t1_start_lo3", DATA_W'(link_start), '0);
        waitBusy(1'b1, 20, "t1_busy_rise");
        chk("t1_busy", DATA_W'(busy), DATA_W'(1));
        chk("t1_owner", DATA_W'(owner), DATA_W'(2));
        waitBusy(1'b0, 200, "t1_busy_fall");
        @(posedge clk); #1;
        chk("t1_done", DATA_W'(req_done), DATA_W'(4'b0100));
        @(posedge clk); #1;
        chk("t1_idle", DATA_W'(busy), '0);
        chk("t1_buf_held", link_send_buf, 256'hA5);
        waitQ(0, 20, "t1_drain");

        // 2: round-robin over all four, then over 0 and 3
        for (int i = 0; i < NUM_REQ; i++) setReq(i, dataFor(i));
        busyLen = 5;
        expectFrame(0, EV_DONE); expectFrame(1, EV_DONE);
        expectFrame(2, EV_DONE); expectFrame(3, EV_DONE);
        expectFrame(0, EV_DONE); expectFrame(3, EV_DONE);
        expectFrame(0, EV_DONE); expectFrame(3, EV_DONE);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitQ(8, 400, "t2_first4");
        req_valid = 4'b1001;
        waitQ(1, 400, "t2_last_grant");
        req_valid = '0;
        waitQ(0, 100, "t2_drain");

        // 3a: busy never rises -> timeout from WAIT_BUSY, next requester served
        busyMode = 1;
        expectFrame(1, EV_ERR);
        expectFrame(2, EV_ERR);
        @(negedge clk);
        req_valid = 4'b0110;
        waitQ(2, 300, "t3_err1");
        req_valid = 4'b0100;
        waitQ(1, 100, "t3_grant2");
        req_valid = '0;
        waitQ(0, 300, "t3_err2");
        chk("t3_wait_timeout", DATA_W'(errCyc - fallCyc), DATA_W'(TIMEOUT));

        // 3b: busy stuck high -> timeout from XFER
        busyMode = 2;
        expectFrame(3, EV_ERR);
        @(negedge clk);
        req_valid = 4'b1000;
        waitQ(1, 50, "t3_grant3");
        req_valid = '0;
        waitQ(0, 300, "t3_err3");
        chk("t3_xfer_timeout", DATA_W'(errCyc - fallCyc), DATA_W'(TIMEOUT + 1));
        busyMode = 0;
        repeat (3) @(negedge clk);

        // 4: link not ready holds off the grant
        busyLen = 10;
        link_ready_send = 1'b0;
        req_valid = 4'b0001;
        repeat (50) @(negedge clk);
        chk("t4_held_idle", DATA_W'(busy), '0);
        @(posedge clk); #1;
        expectFrame(0, EV_DONE);
        link_ready_send = 1'b1;
        @(posedge clk); #1;
        chk("t4_grant", DATA_W'(req_ready), DATA_W'(4'b0001));
        req_valid = '0;
        waitQ(0, 200, "t4_drain");

        // 5: receive buffer, overflow, back-to-back capture
        @(posedge clk); #1;
        link_rx_buf = fx; link_rx_new = 1'b1;
        @(posedge clk); #1;
        link_rx_new = 1'b0;
        chk("t5_valid", DATA_W'(rx_valid), DATA_W'(1));
        chk("t5_data_x", rx_data, fx);
        link_rx_buf = fy; link_rx_new = 1'b1;
        @(posedge clk); #1;
        link_rx_new = 1'b0;
        chk("t5_kept_x", rx_data, fx);
        chk("t5_overflow", DATA_W'(rx_overflow), DATA_W'(1));
        rxQ.push_back(fx);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_drained", DATA_W'(rx_valid), '0);
        rxQ.push_back(fz);
        rxQ.push_back(fw);
        link_rx_buf = fz; link_rx_new = 1'b1;
        @(posedge clk); #1;
        link_rx_buf = fw;
        @(posedge clk); #1;
        link_rx_new = 1'b0;
        chk("t5_data_w", rx_data, fw);
        @(posedge clk); #1;
        chk("t5_empty", DATA_W'(rx_valid), '0);
        chk("t5_ovf_sticky", DATA_W'(rx_overflow), DATA_W'(1));
        rx_ready = 1'b0;

        // 6: reset in the middle of requester 2's transfer
        busyLen = 60;
        pushEv(EV_READY, 4'b0100, dataFor(2));
        @(negedge clk);
        req_valid = 4'b0100;
        waitQ(0, 50, "t6_grant2");
        req_valid = '0;
        waitBusy(1'b1, 30, "t6_busy_rise");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_start", DATA_W'(link_start), '0);
        chk("t6_busy", DATA_W'(busy), '0);
        chk("t6_done", DATA_W'(req_done), '0);
        chk("t6_owner", DATA_W'(owner), '0);
        req_valid = 4'b1111;
        waitBusy(1'b0, 200, "t6_link_quiet");
        expectFrame(0, EV_DONE);
        @(negedge clk);
        rst = 1'b0;
        waitQ(1, 50, "t6_grant0");
        req_valid = '0;
        waitQ(0, 300, "t6_drain");

        repeat (5) @(negedge clk);
        chk("end_expq", DATA_W'(expQ.size()), '0);
        chk("end_rxq", DATA_W'(rxQ.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
